alu_operand_stage: RTL and testbench

ID/EX pipeline register and operand-forwarding front end for the execute stage. It captures decoded instructions, detects load-use hazards, and drives the ALU operand inputs `Reg1`, `Reg2` and `operation` with forwarded values from the MEM and WB stages. It sits between the decode stage, which contains the register file, and the ALU. The register file is write-through, so same-cycle WB→ID bypass is outside this block.

---
 rtl/alu_operand_stage.sv | 151 +++++++++++++++
 tb/tb_alu_operand_stage.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding and load-use hazard
// detection, feeding Reg1/Reg2/operation to the ALU.

module alu_fwd_mux (
  input  logic [4:0]  src,
  input  logic [31:0] latched,
  input  logic        mem_reg_write,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_result,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_result,
  output logic [31:0] data
);
  logic mem_hit, wb_hit;

  // r0 is hardwired zero, so a write to it is never forwarded
  assign mem_hit = mem_reg_write && (mem_rd != 5'd0) && (mem_rd == src);
  assign wb_hit  = wb_reg_write  && (wb_rd  != 5'd0) && (wb_rd  == src);

  always_comb begin
    data = latched;
    if (mem_hit)     data = mem_result;
    else if (wb_hit) data = wb_result;
  end
endmodule

module alu_operand_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [31:0] id_imm,
  input  logic        id_use_imm,
  input  logic [3:0]  id_operation,
  input  logic        id_mem_read,
  input  logic        id_mem_write,
  input  logic        id_reg_write,
  input  logic        flush,
  input  logic        ex_hold,
  input  logic        mem_reg_write,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_result,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_result,
  output logic [31:0] Reg1,
  output logic [31:0] Reg2,
  output logic [3:0]  operation,
  output logic        ex_valid,
  output logic [4:0]  ex_rd,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic [31:0] ex_store_data,
  output logic        id_stall
);
  localparam int NUM_SRC = 2;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic        use_imm;
    logic [3:0]  op;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
  } id_ex_t;

  id_ex_t ex;

  logic [NUM_SRC-1:0][4:0]  src_idx;
  logic [NUM_SRC-1:0][31:0] src_data;
  logic [NUM_SRC-1:0][31:0] fwd_data;
  logic                     hazard;

  assign src_idx  = {ex.rt, ex.rs};
  assign src_data = {ex.rt_data, ex.rs_data};

  // slot 0 forwards rs, slot 1 forwards rt
  for (genvar s = 0; s < NUM_SRC; s++) begin : g_fwd
    alu_fwd_mux u_fwd (
      .src          (src_idx[s]),
      .latched      (src_data[s]),
      .mem_reg_write(mem_reg_write),
      .mem_rd       (mem_rd),
      .mem_result   (mem_result),
      .wb_reg_write (wb_reg_write),
      .wb_rd        (wb_rd),
      .wb_result    (wb_result),
      .data         (fwd_data[s])
    );
  end

  // rt is compared even for immediate forms because stores read it
  assign hazard = ex.valid && ex.mem_read && (ex.rd != 5'd0) && id_valid &&
                  ((id_rs == ex.rd) || (id_rt == ex.rd));
  assign id_stall = hazard || ex_hold;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex <= '0;
    end else if (flush) begin
      ex.valid     <= 1'b0;
      ex.mem_read  <= 1'b0;
      ex.mem_write <= 1'b0;
      ex.reg_write <= 1'b0;
    end else if (ex_hold) begin
      // capture values retiring from WB while frozen so they are not lost
      ex.rs_data <= fwd_data[0];
      ex.rt_data <= fwd_data[1];
    end else if (hazard) begin
      ex.valid     <= 1'b0;
      ex.mem_read  <= 1'b0;
      ex.mem_write <= 1'b0;
      ex.reg_write <= 1'b0;
    end else begin
      ex.valid     <= id_valid;
      ex.rs        <= id_rs;
      ex.rt        <= id_rt;
      ex.rd        <= id_rd;
      ex.rs_data   <= id_rs_data;
      ex.rt_data   <= id_rt_data;
      ex.imm       <= id_imm;
      ex.use_imm   <= id_use_imm;
      ex.op        <= id_operation;
      ex.mem_read  <= id_mem_read  && id_valid;
      ex.mem_write <= id_mem_write && id_valid;
      ex.reg_write <= id_reg_write && id_valid;
    end
  end

  assign Reg1          = fwd_data[0];
  assign ex_store_data = fwd_data[1];
  assign Reg2          = ex.use_imm ? ex.imm : fwd_data[1];
  assign operation     = ex.op;
  assign ex_valid      = ex.valid;
  assign ex_rd         = ex.rd;
  assign ex_reg_write  = ex.valid && ex.reg_write;
  assign ex_mem_read   = ex.valid && ex.mem_read;
  assign ex_mem_write  = ex.valid && ex.mem_write;
endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed plus randomized bench for alu_operand_stage against a cycle-level
// behavioural model of the EX slot.

module tb_alu_operand_stage;
  logic clk = 1'b0;
  logic reset;
  logic idv, iui, imr, imw, irw, fl, hold, mrw, wrw;
  logic [4:0] irs, irt, ird, mrd, wrd;
  logic [31:0] irsd, irtd, iimm, mres, wres;
  logic [3:0] iop;
  logic [31:0] reg1, reg2, store;
  logic [3:0] op;
  logic ex_valid, ex_rw, ex_mr, ex_mw, stall;
  logic [4:0] ex_rd;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_operand_stage dut (
    .clk(clk), .reset(reset), .id_valid(idv), .id_rs(irs), .id_rt(irt), .id_rd(ird),
    .id_rs_data(irsd), .id_rt_data(irtd), .id_imm(iimm), .id_use_imm(iui),
    .id_operation(iop), .id_mem_read(imr), .id_mem_write(imw), .id_reg_write(irw),
    .flush(fl), .ex_hold(hold), .mem_reg_write(mrw), .mem_rd(mrd), .mem_result(mres),
    .wb_reg_write(wrw), .wb_rd(wrd), .wb_result(wres), .Reg1(reg1), .Reg2(reg2),
    .operation(op), .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_write(ex_rw),
    .ex_mem_read(ex_mr), .ex_mem_write(ex_mw), .ex_store_data(store), .id_stall(stall)
  );

  // Model of the instruction sitting in EX; known=0 means its data fields are don't-care
  typedef struct {
    bit valid, known, ui, mr, mw, rw;
    bit [4:0] rs, rt, rd;
    bit [31:0] rsd, rtd, imm;
    bit [3:0] op;
  } slot_t;
  slot_t m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit [31:0] fwd(input bit [4:0] s, input bit [31:0] d);
    if (mrw && mrd != 0 && mrd == s) return mres;
    if (wrw && wrd != 0 && wrd == s) return wres;
    return d;
  endfunction

  function automatic bit hz();
    return m.valid && m.mr && m.rd != 0 && idv && (irs == m.rd || irt == m.rd);
  endfunction

  task automatic model_clear();
    m = '{default: 0};
    m.known = 1;
  endtask

  task automatic check_all();
    bit [31:0] st;
    st = fwd(m.rt, m.rtd);
    chk("ex_valid", ex_valid, 32'(m.valid));
    chk("ex_reg_write", ex_rw, 32'(m.valid & m.rw));
    chk("ex_mem_read", ex_mr, 32'(m.valid & m.mr));
    chk("ex_mem_write", ex_mw, 32'(m.valid & m.mw));
    chk("id_stall", stall, 32'(hz() | hold));
    if (m.known) begin
      chk("Reg1", reg1, fwd(m.rs, m.rsd));
      chk("Reg2", reg2, m.ui ? m.imm : st);
      chk("store_data", store, st);
      chk("operation", 32'(op), 32'(m.op));
      chk("ex_rd", 32'(ex_rd), 32'(m.rd));
    end
  endtask

  // One clock: settle, check, advance model at the edge, return 1 time unit after it
  task automatic cyc();
    slot_t n;
    #1;
    check_all();
    n = m;
    if (reset) begin
      n = '{default: 0};
      n.known = 1;
    end else if (fl) begin
      n.valid = 0; n.rw = 0; n.mr = 0; n.mw = 0; n.known = 0;
    end else if (hold) begin
      n.rsd = fwd(m.rs, m.rsd);
      n.rtd = fwd(m.rt, m.rtd);
    end else if (hz()) begin
      n.valid = 0; n.rw = 0; n.mr = 0; n.mw = 0; n.known = 0;
    end else begin
      n.valid = idv; n.known = 1;
      n.rs = irs; n.rt = irt; n.rd = ird; n.rsd = irsd; n.rtd = irtd;
      n.imm = iimm; n.ui = iui; n.op = iop;
      n.mr = imr & idv; n.mw = imw & idv; n.rw = irw & idv;
    end
    @(posedge clk);
    m = n;
    #1;
  endtask

  task automatic idle_inputs();
    idv = 0; irs = 0; irt = 0; ird = 0; irsd = 0; irtd = 0; iimm = 0; iui = 0;
    iop = 0; imr = 0; imw = 0; irw = 0; fl = 0; hold = 0;
    mrw = 0; mrd = 0; mres = 0; wrw = 0; wrd = 0; wres = 0;
  endtask

  task automatic present(input bit [4:0] rs, input bit [4:0] rt, input bit [4:0] rd,
                         input bit [31:0] rsd, input bit [31:0] rtd, input bit [3:0] opc,
                         input bit mr, input bit rw);
    idv = 1; irs = rs; irt = rt; ird = rd; irsd = rsd; irtd = rtd; iop = opc;
    imr = mr; irw = rw; imw = 0; iui = 0; iimm = 0;
  endtask

  initial begin
    bit [3:0] ops [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};
    idle_inputs();
    m = '{default: 0};
    reset = 1;
    model_clear();
    // Reset with a valid instruction presented
    present(3, 4, 5, 5, 7, 4'b0010, 0, 1);
    #2;
    chk("rst_Reg1", reg1, 0);
    chk("rst_Reg2", reg2, 0);
    chk("rst_valid", ex_valid, 0);
    chk("rst_stall", stall, 0);
    hold = 1; #1;
    chk("rst_stall_hold", stall, 1);
    hold = 0;
    cyc();
    cyc();
    reset = 0;
    cyc();
    // ADD rs=3 rt=4 is now in EX
    idle_inputs();
    #1;
    chk("add_Reg1", reg1, 5);
    chk("add_Reg2", reg2, 7);
    chk("add_op", 32'(op), 32'h2);
    chk("add_valid", ex_valid, 1);
    // MEM beats WB; r0 in MEM falls through to WB
    mrw = 1; mrd = 3; mres = 32'hAA; wrw = 1; wrd = 3; wres = 32'hBB;
    #1; chk("fwd_mem", reg1, 32'hAA);
    mrd = 0;
    #1; chk("fwd_wb", reg1, 32'hBB);
    cyc();
    // Load-use: LW r8 then dependent on r8
    idle_inputs();
    present(1, 2, 8, 100, 0, 4'b0010, 1, 1);
    cyc();
    present(8, 2, 9, 32'hBAD, 3, 4'b0010, 0, 1);
    #1; chk("lu_stall", stall, 1);
    cyc();
    chk("lu_bubble", ex_valid, 0);
    chk("lu_stall_drop", stall, 0);
    mrw = 1; mrd = 8; mres = 32'hF00D;
    cyc();
    idle_inputs();
    wrw = 1; wrd = 8; wres = 32'hDEAD;
    #1;
    chk("lu_valid", ex_valid, 1);
    chk("lu_wb_fwd", reg1, 32'hDEAD);
    cyc();
    // Hold three cycles while WB retires r9 once
    idle_inputs();
    present(1, 9, 10, 1, 32'h1111, 4'b0110, 0, 1);
    cyc();
    present(2, 3, 11, 32'h22, 32'h33, 4'b0001, 0, 1);
    hold = 1; wrw = 1; wrd = 9; wres = 32'h1234;
    cyc();
    wrw = 0; wres = 0;
    cyc();
    cyc();
    hold = 0;
    #1;
    chk("hold_Reg2", reg2, 32'h1234);
    chk("hold_store", store, 32'h1234);
    chk("hold_rd", 32'(ex_rd), 10);
    cyc();
    idv = 0;
    #1;
    chk("hold_next_rd", 32'(ex_rd), 11);
    chk("hold_next_Reg1", reg1, 32'h22);
    cyc();
    // Flush beats hold
    present(4, 5, 6, 1, 2, 4'b0000, 0, 1);
    fl = 1; hold = 1;
    cyc();
    idle_inputs();
    #1;
    chk("flush_valid", ex_valid, 0);
    chk("flush_rw", ex_rw, 0);
    // Immediate path with rt forwarded from MEM
    present(1, 6, 7, 0, 0, 4'b0010, 0, 1);
    iui = 1; iimm = 32'hFFFFFFFC; imw = 1;
    cyc();
    idle_inputs();
    mrw = 1; mrd = 6; mres = 32'h55;
    #1;
    chk("imm_Reg2", reg2, 32'hFFFFFFFC);
    chk("imm_store", store, 32'h55);
    chk("imm_mw", ex_mw, 1);
    // Asynchronous reset mid-cycle
    reset = 1;
    model_clear();
    #1;
    chk("arst_valid", ex_valid, 0);
    chk("arst_Reg2", reg2, 0);
    cyc();
    reset = 0;
    idle_inputs();
    // Random traffic over a small register set to exercise forwarding and hazards
    for (int i = 0; i < 400; i++) begin
      idv  = ($urandom_range(0, 3) != 0);
      irs  = 5'($urandom_range(0, 7)); irt = 5'($urandom_range(0, 7));
      ird  = 5'($urandom_range(0, 7));
      irsd = $urandom; irtd = $urandom; iimm = $urandom;
      iui  = 1'($urandom); iop = ops[$urandom_range(0, 5)];
      imr  = ($urandom_range(0, 2) == 0); imw = 1'($urandom); irw = 1'($urandom);
      fl   = ($urandom_range(0, 11) == 0); hold = ($urandom_range(0, 5) == 0);
      mrw  = 1'($urandom); mrd = 5'($urandom_range(0, 7)); mres = $urandom;
      wrw  = 1'($urandom); wrd = 5'($urandom_range(0, 7)); wres = $urandom;
      if ($urandom_range(0, 49) == 0) begin
        reset = 1;
        model_clear();
      end else begin
        reset = 0;
      end
      cyc();
    end
    reset = 0;
    idle_inputs();
    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
